// File: rtl/vga_line_loader_pkg.sv
// -----------------------------------------------------------------------------
// vga_line_loader_pkg
//   Shared VGA line-loader parameters, common with the timing controller:
//   active line width, memory burst geometry, address width and line-FIFO
//   geometry, plus a helper that decides whether the line FIFO can take
//   another full burst.
// -----------------------------------------------------------------------------
package vga_line_loader_pkg;

  localparam int H_ACTIVE   = 1024;  // pixels per line, words per line load
  localparam int BURST_LEN  = 256;   // words per memory burst
  localparam int ADDR_W     = 23;    // memory word-address width
  localparam int FIFO_DEPTH = 2048;  // line-FIFO depth in words
  localparam int FIFO_AW    = 11;    // width of the FIFO used-words count
  localparam int VLINE_W    = 13;    // line-number width
  localparam int PIX_W      = 24;    // {R,G,B}
  localparam int LEN_W      = 9;     // burst-length field width

  localparam int N_BURSTS   = H_ACTIVE / BURST_LEN;
  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int IDX_W      = $clog2(N_BURSTS + 1);

  // A burst may only be requested when the whole burst fits in the FIFO.
  // The used-words count is widened to int so that DEPTH - used never wraps.
  function automatic logic fifoHasRoom(input logic [FIFO_AW-1:0] usedw);
    return (FIFO_DEPTH - int'(usedw)) >= BURST_LEN;
  endfunction

endpackage

// File: rtl/vga_line_loader_if.sv
// -----------------------------------------------------------------------------
// vga_line_loader_if
//   Bundles the frame-buffer burst-read port and the line-FIFO write side.
//   master : the line loader (issues reads, writes the FIFO)
//   slave  : the memory controller / FIFO side
//   Signals:
//     oMEM_RD_REQ / oMEM_RD_ADDR / oMEM_RD_LEN  burst request, start, length
//     iMEM_RD_ACK                               burst accepted
//     iMEM_RD_VALID / iMEM_RD_DATA              returned data beats
//     oFIFO_WDATA / oFIFO_WREQ                  FIFO write port
//     iFIFO_WUSEDW                              FIFO write-side fill level
//     oFIFO_ACLR                                FIFO clear
// -----------------------------------------------------------------------------
interface vga_line_loader_if;
  import vga_line_loader_pkg::*;

  logic               oMEM_RD_REQ;
  logic [ADDR_W-1:0]  oMEM_RD_ADDR;
  logic [LEN_W-1:0]   oMEM_RD_LEN;
  logic               iMEM_RD_ACK;
  logic               iMEM_RD_VALID;
  logic [PIX_W-1:0]   iMEM_RD_DATA;
  logic [PIX_W-1:0]   oFIFO_WDATA;
  logic               oFIFO_WREQ;
  logic [FIFO_AW-1:0] iFIFO_WUSEDW;
  logic               oFIFO_ACLR;

  modport master (
    output oMEM_RD_REQ, oMEM_RD_ADDR, oMEM_RD_LEN,
    input  iMEM_RD_ACK, iMEM_RD_VALID, iMEM_RD_DATA,
    output oFIFO_WDATA, oFIFO_WREQ, oFIFO_ACLR,
    input  iFIFO_WUSEDW
  );

  modport slave (
    input  oMEM_RD_REQ, oMEM_RD_ADDR, oMEM_RD_LEN,
    output iMEM_RD_ACK, iMEM_RD_VALID, iMEM_RD_DATA,
    input  oFIFO_WDATA, oFIFO_WREQ, oFIFO_ACLR,
    output iFIFO_WUSEDW
  );

endinterface

// File: rtl/vga_line_loader_addr_gen.sv
// -----------------------------------------------------------------------------
// vga_line_loader_addr_gen
//   Burst address generator for one line load: line base multiply, burst
//   index and the registered burst start address.
//   Ports:
//     iCLK, iRST_N   clock, synchronous active-low reset
//     iSTART         load base = iVLINE * H_ACTIVE, index = 0
//     iADVANCE       step to the next burst (index + 1, address + BURST_LEN)
//     iVLINE         line number, sampled with iSTART
//     oADDR          current burst start address (registered, stable)
//     oLAST_BURST    current burst is the final one of the line
// -----------------------------------------------------------------------------
module vga_line_loader_addr_gen
  import vga_line_loader_pkg::*;
(
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iSTART,
  input  logic               iADVANCE,
  input  logic [VLINE_W-1:0] iVLINE,
  output logic [ADDR_W-1:0]  oADDR,
  output logic               oLAST_BURST
);

  localparam logic [ADDR_W-1:0] LINE_STRIDE  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_LEN);

  logic [IDX_W-1:0]  burstIdx;
  logic [ADDR_W-1:0] baseAddr;

  // Product is evaluated at ADDR_W bits, so it truncates to the address width.
  assign baseAddr = ADDR_W'(iVLINE) * LINE_STRIDE;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      burstIdx <= '0;
      oADDR    <= '0;
    end else if (iSTART) begin
      burstIdx <= '0;
      oADDR    <= baseAddr;
    end else if (iADVANCE) begin
      burstIdx <= burstIdx + IDX_W'(1);
      oADDR    <= oADDR + BURST_STRIDE;
    end
  end

  assign oLAST_BURST = (burstIdx == IDX_W'(N_BURSTS - 1));

endmodule

// File: rtl/vga_line_loader.sv
// -----------------------------------------------------------------------------
// vga_line_loader
//   Fills the VGA read-side line FIFO from frame-buffer memory, one video line
//   per load request, as H_ACTIVE/BURST_LEN bursts with one outstanding.
//   Ports:
//     iCLK, iRST_N   pixel clock, synchronous active-low reset
//     iLOAD_REQ      line-load request (rising edge acts)
//     iLOAD_VLINE    line number, sampled on the request edge
//     iCLEAR         FIFO clear / load abort (level)
//     oBUSY          a line load is in progress
//     oOVERRUN       one-cycle pulse when a request arrives while busy
//     bus            memory burst-read port and FIFO write port (master)
// -----------------------------------------------------------------------------
module vga_line_loader
  import vga_line_loader_pkg::*;
(
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iLOAD_REQ,
  input  logic [VLINE_W-1:0] iLOAD_VLINE,
  input  logic               iCLEAR,
  output logic               oBUSY,
  output logic               oOVERRUN,
  vga_line_loader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RECV, FLUSH} state_t;

  state_t            state, stateNxt;
  logic [BEAT_W-1:0] beatCnt, beatCntNxt;
  logic              memRdReq, memRdReqNxt;
  logic              fifoWreq, fifoWreqNxt;
  logic [PIX_W-1:0]  fifoWdata, fifoWdataNxt;
  logic              overrun, overrunNxt;
  logic              fifoAclr;
  logic [LEN_W-1:0]  memRdLen;
  logic [ADDR_W-1:0] memRdAddr;
  logic              loadReqD;
  logic              armed;

  logic loadRise, spaceOk, beatLast, lastBurst, addrStart, addrAdvance;

  // A request held high through reset release must not start a load, so the
  // edge detector is only armed once iLOAD_REQ has been seen low after reset.
  assign loadRise = iLOAD_REQ & ~loadReqD & armed;
  assign spaceOk  = fifoHasRoom(bus.iFIFO_WUSEDW);
  assign beatLast = bus.iMEM_RD_VALID && (beatCnt == BEAT_W'(BURST_LEN - 1));

  vga_line_loader_addr_gen u_addr_gen (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iSTART      (addrStart),
    .iADVANCE    (addrAdvance),
    .iVLINE      (iLOAD_VLINE),
    .oADDR       (memRdAddr),
    .oLAST_BURST (lastBurst)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= IDLE;
      beatCnt   <= '0;
      memRdReq  <= 1'b0;
      fifoWreq  <= 1'b0;
      fifoWdata <= '0;
      overrun   <= 1'b0;
      fifoAclr  <= 1'b0;
      memRdLen  <= '0;
      loadReqD  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= stateNxt;
      beatCnt   <= beatCntNxt;
      memRdReq  <= memRdReqNxt;
      fifoWreq  <= fifoWreqNxt;
      fifoWdata <= fifoWdataNxt;
      overrun   <= overrunNxt;
      fifoAclr  <= iCLEAR;
      memRdLen  <= LEN_W'(BURST_LEN);
      loadReqD  <= iLOAD_REQ;
      armed     <= armed | ~iLOAD_REQ;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    stateNxt     = state;
    beatCntNxt   = beatCnt;
    memRdReqNxt  = 1'b0;
    fifoWreqNxt  = 1'b0;
    fifoWdataNxt = fifoWdata;
    overrunNxt   = 1'b0;
    addrStart    = 1'b0;
    addrAdvance  = 1'b0;

    if (iCLEAR) begin
      // Clear aborts the load and beats the FIFO rather than the request.
      // An accepted burst is still drained so its tail is not mistaken for
      // the next load's data; a pending, unaccepted request is just dropped.
      unique case (state)
        RECV, FLUSH: begin
          if (bus.iMEM_RD_VALID) beatCntNxt = beatCnt + BEAT_W'(1);
          stateNxt = beatLast ? IDLE : FLUSH;
        end
        ISSUE: begin
          if (memRdReq && bus.iMEM_RD_ACK) begin
            beatCntNxt = '0;
            stateNxt   = FLUSH;
          end else begin
            stateNxt = IDLE;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end else begin
      if (loadRise && state != IDLE) overrunNxt = 1'b1;

      unique case (state)
        IDLE: begin
          if (loadRise) begin
            addrStart   = 1'b1;
            memRdReqNxt = spaceOk;
            stateNxt    = ISSUE;
          end
        end

        ISSUE: begin
          // Once raised, the request is held regardless of FIFO level until
          // the memory accepts it.
          if (memRdReq) begin
            if (bus.iMEM_RD_ACK) begin
              beatCntNxt = '0;
              stateNxt   = RECV;
            end else begin
              memRdReqNxt = 1'b1;
            end
          end else begin
            memRdReqNxt = spaceOk;
          end
        end

        RECV: begin
          if (bus.iMEM_RD_VALID) begin
            fifoWreqNxt  = 1'b1;
            fifoWdataNxt = bus.iMEM_RD_DATA;
            beatCntNxt   = beatCnt + BEAT_W'(1);
          end
          if (beatLast) begin
            addrAdvance = 1'b1;
            if (lastBurst) begin
              stateNxt = IDLE;
            end else begin
              memRdReqNxt = spaceOk;
              stateNxt    = ISSUE;
            end
          end
        end

        FLUSH: begin
          if (bus.iMEM_RD_VALID) beatCntNxt = beatCnt + BEAT_W'(1);
          if (beatLast) stateNxt = IDLE;
        end

        default: stateNxt = IDLE;
      endcase
    end
  end

  assign oBUSY    = (state != IDLE);
  assign oOVERRUN = overrun;

  assign bus.oMEM_RD_REQ  = memRdReq;
  assign bus.oMEM_RD_ADDR = memRdAddr;
  assign bus.oMEM_RD_LEN  = memRdLen;
  assign bus.oFIFO_WREQ   = fifoWreq;
  assign bus.oFIFO_WDATA  = fifoWdata;
  assign bus.oFIFO_ACLR   = fifoAclr;

endmodule

// File: tb/tb_vga_line_loader.sv
// -----------------------------------------------------------------------------
// tb_vga_line_loader
//   Directed self-checking bench for vga_line_loader. Inputs change 1 time
//   unit after the rising edge; outputs are sampled at the same point, so a
//   value checked after tick() is the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_vga_line_loader;
  import vga_line_loader_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               loadReq;
  logic [VLINE_W-1:0] loadVline;
  logic               clear;
  logic               busy;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int wrCount  = 0;
  int ovCount  = 0;
  int wrBase;
  int ovBase;

  always #5 clk = ~clk;

  vga_line_loader_if bus ();

  vga_line_loader dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iLOAD_REQ   (loadReq),
    .iLOAD_VLINE (loadVline),
    .iCLEAR      (clear),
    .oBUSY       (busy),
    .oOVERRUN    (overrun),
    .bus         (bus)
  );

  // Counts FIFO writes and overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.oFIFO_WREQ === 1'b1) wrCount++;
    if (overrun === 1'b1)        ovCount++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Request edge, check the t+1 response, hold the request a second cycle.
  task automatic startLoad(input logic [VLINE_W-1:0] vline, input logic expReq, input string tag);
    loadVline = vline;
    loadReq   = 1'b1;
    tick();
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_req_t1"}, bus.oMEM_RD_REQ, expReq);
    tick();
    loadReq = 1'b0;
  endtask

  // Wait (bounded) for the burst request, hold ACK off for ackDelay cycles
  // while checking the request stays put, then accept it.
  task automatic handshake(input int ackDelay, input logic [ADDR_W-1:0] expAddr, input string tag);
    int n = 0;
    while (bus.oMEM_RD_REQ !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, bus.oMEM_RD_REQ, 1);
    check({tag, "_addr"}, bus.oMEM_RD_ADDR, expAddr);
    check({tag, "_len"}, bus.oMEM_RD_LEN, 256);
    for (int i = 0; i < ackDelay; i++) begin
      tick();
      check({tag, "_req_hold"}, bus.oMEM_RD_REQ, 1);
      check({tag, "_addr_hold"}, bus.oMEM_RD_ADDR, expAddr);
    end
    bus.iMEM_RD_ACK = 1'b1;
    tick();
    bus.iMEM_RD_ACK = 1'b0;
    check({tag, "_req_drop"}, bus.oMEM_RD_REQ, 0);
  endtask

  // Stream n back-to-back beats; each must (or must not) appear as a FIFO
  // write on the following cycle.
  task automatic streamBeats(input int n, input int firstData, input logic expWr, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.iMEM_RD_VALID = 1'b1;
      bus.iMEM_RD_DATA  = PIX_W'(firstData + i);
      tick();
      check({tag, "_wreq"}, bus.oFIFO_WREQ, expWr);
      if (expWr) check({tag, "_wdata"}, bus.oFIFO_WDATA, 32'(firstData + i));
    end
    bus.iMEM_RD_VALID = 1'b0;
  endtask

  logic [ADDR_W-1:0] addr5 [4];
  logic [ADDR_W-1:0] addr7 [4];

  initial begin
    addr5 = '{23'd5120, 23'd5376, 23'd5632, 23'd5888};
    addr7 = '{23'd7168, 23'd7424, 23'd7680, 23'd7936};

    rst_n             = 1'b0;
    loadReq           = 1'b1;   // held high through reset release
    loadVline         = 13'd1;
    clear             = 1'b0;
    bus.iMEM_RD_ACK   = 1'b0;
    bus.iMEM_RD_VALID = 1'b0;
    bus.iMEM_RD_DATA  = '0;
    bus.iFIFO_WUSEDW  = '0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_req", bus.oMEM_RD_REQ, 0);
    check("rst_addr", bus.oMEM_RD_ADDR, 0);
    check("rst_len", bus.oMEM_RD_LEN, 0);
    check("rst_wreq", bus.oFIFO_WREQ, 0);
    check("rst_wdata", bus.oFIFO_WDATA, 0);
    check("rst_aclr", bus.oFIFO_ACLR, 0);
    check("rst_overrun", overrun, 0);

    // ---- request held through reset release starts nothing ----
    rst_n = 1'b1;
    tick();
    check("held_busy_1", busy, 0);
    tick();
    check("held_busy_2", busy, 0);
    check("held_req", bus.oMEM_RD_REQ, 0);
    check("len_after_rst", bus.oMEM_RD_LEN, 256);
    loadReq = 1'b0;
    repeat (2) tick();

    // ---- single load, line 5, immediate ACK, streaming data ----
    wrBase = wrCount;
    startLoad(13'd5, 1'b1, "load5");
    for (int b = 0; b < 4; b++) begin
      handshake(0, addr5[b], $sformatf("load5_b%0d", b));
      streamBeats(256, 256 * b, 1'b1, $sformatf("load5_b%0d", b));
      if (b < 3) check($sformatf("load5_busy_mid%0d", b), busy, 1);
    end
    check("load5_busy_end", busy, 0);
    tick();
    check("load5_wrcount", wrCount - wrBase, 1024);
    check("load5_wreq_after", bus.oFIFO_WREQ, 0);

    // ---- back-pressure: 1800 and 1793 used block, 1792 allows ----
    bus.iFIFO_WUSEDW = 11'd1800;
    startLoad(13'd8191, 1'b0, "bp");
    repeat (3) tick();
    check("bp_req_1800", bus.oMEM_RD_REQ, 0);
    check("bp_busy", busy, 1);
    bus.iFIFO_WUSEDW = 11'd1793;
    tick();
    check("bp_req_1793", bus.oMEM_RD_REQ, 0);
    bus.iFIFO_WUSEDW = 11'd1792;
    tick();
    check("bp_req_1792", bus.oMEM_RD_REQ, 1);
    check("bp_addr_max_line", bus.oMEM_RD_ADDR, 32'h7F_FC00);
    bus.iFIFO_WUSEDW = '0;

    // ---- clear while the request is pending: dropped, straight to IDLE ----
    clear = 1'b1;
    tick();
    check("clr_issue_aclr", bus.oFIFO_ACLR, 1);
    check("clr_issue_req", bus.oMEM_RD_REQ, 0);
    check("clr_issue_busy", busy, 0);
    clear = 1'b0;
    tick();
    check("clr_issue_aclr_off", bus.oFIFO_ACLR, 0);

    // ---- clear and request edge together: clear wins, no overrun ----
    clear     = 1'b1;
    loadReq   = 1'b1;
    loadVline = 13'd4;
    tick();
    check("clr_edge_busy", busy, 0);
    check("clr_edge_overrun", overrun, 0);
    check("clr_edge_aclr", bus.oFIFO_ACLR, 1);
    clear = 1'b0;
    tick();
    check("clr_edge_busy_hold", busy, 0);
    loadReq = 1'b0;
    tick();

    // ---- clear after 100 of 256 beats ----
    wrBase = wrCount;
    startLoad(13'd2, 1'b1, "cmid");
    handshake(0, 23'd2048, "cmid");
    streamBeats(100, 0, 1'b1, "cmid_pre");
    clear             = 1'b1;
    bus.iMEM_RD_VALID = 1'b1;
    bus.iMEM_RD_DATA  = 24'd100;
    tick();
    clear = 1'b0;
    check("cmid_aclr", bus.oFIFO_ACLR, 1);
    check("cmid_wreq_at_clr", bus.oFIFO_WREQ, 0);
    check("cmid_req", bus.oMEM_RD_REQ, 0);
    check("cmid_busy_flush", busy, 1);
    streamBeats(154, 101, 1'b0, "cmid_drop");
    check("cmid_busy_b255", busy, 1);
    streamBeats(1, 255, 1'b0, "cmid_last");
    check("cmid_busy_b256", busy, 0);
    streamBeats(5, 300, 1'b0, "cmid_idle_beats");
    check("cmid_wrcount", wrCount - wrBase, 100);

    // ---- overrun during RECV; second burst ACK held off 7 cycles ----
    wrBase = wrCount;
    ovBase = ovCount;
    startLoad(13'd7, 1'b1, "ovr");
    handshake(0, addr7[0], "ovr_b0");
    streamBeats(50, 0, 1'b1, "ovr_b0a");
    loadReq   = 1'b1;
    loadVline = 13'd99;
    streamBeats(1, 50, 1'b1, "ovr_b0b");
    check("ovr_pulse", overrun, 1);
    streamBeats(1, 51, 1'b1, "ovr_b0c");
    check("ovr_pulse_end", overrun, 0);
    loadReq = 1'b0;
    streamBeats(204, 52, 1'b1, "ovr_b0d");
    handshake(7, addr7[1], "ovr_b1_ackdly");
    streamBeats(256, 256, 1'b1, "ovr_b1");
    handshake(0, addr7[2], "ovr_b2");
    streamBeats(256, 512, 1'b1, "ovr_b2");
    handshake(0, addr7[3], "ovr_b3");
    streamBeats(256, 768, 1'b1, "ovr_b3");
    check("ovr_busy_end", busy, 0);
    tick();
    check("ovr_count", ovCount - ovBase, 1);
    check("ovr_wrcount", wrCount - wrBase, 1024);

    // ---- reset for one cycle during RECV ----
    startLoad(13'd3, 1'b1, "rmid");
    handshake(0, 23'd3072, "rmid");
    streamBeats(20, 0, 1'b1, "rmid_pre");
    bus.iMEM_RD_VALID = 1'b1;
    bus.iMEM_RD_DATA  = 24'd20;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmid_busy", busy, 0);
    check("rmid_req", bus.oMEM_RD_REQ, 0);
    check("rmid_addr", bus.oMEM_RD_ADDR, 0);
    check("rmid_len", bus.oMEM_RD_LEN, 0);
    check("rmid_wreq", bus.oFIFO_WREQ, 0);
    check("rmid_wdata", bus.oFIFO_WDATA, 0);
    check("rmid_aclr", bus.oFIFO_ACLR, 0);
    check("rmid_overrun", overrun, 0);
    wrBase = wrCount;
    streamBeats(20, 21, 1'b0, "rmid_late");
    check("rmid_busy_late", busy, 0);
    tick();
    check("rmid_wrcount", wrCount - wrBase, 0);

    // ---- a fresh load is accepted after the reset ----
    startLoad(13'd1, 1'b1, "post");
    check("post_addr", bus.oMEM_RD_ADDR, 23'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
